// File: rtl/pipe_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipe_addsub_unit
// Brief   : Unsigned W-bit add/sub (wrap or saturate) with STAGES-deep
//           valid/ready pipeline, synchronous flush and occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_addsub_unit #(
  parameter int W      = 20,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [W-1:0]                a,
  input  logic [W-1:0]                b,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [W-1:0]                y,
  output logic                        ovf,
  output logic                        valid,
  input  logic                        out_ready,
  output logic [$clog2(STAGES+1)-1:0] inflight
);

  localparam int CW = $clog2(STAGES+1);

  logic [W:0]                 w_full;
  logic [W-1:0]               w_diff;
  logic                       w_borrow;
  logic [W-1:0]               w_res;
  logic                       w_ovf;
  logic                       w_advance;
  logic                       w_accept;

  logic [STAGES-1:0]          r_vld;
  logic [STAGES-1:0][W-1:0]   r_y;
  logic [STAGES-1:0]          r_ovf;

  // op[1] selects saturation, op[0] selects subtraction
  always_comb begin
    w_full   = {1'b0, a} + {1'b0, b};
    w_diff   = a - b;
    w_borrow = (a < b);
    case (op)
      2'b00: begin
        w_res = w_full[W-1:0];
        w_ovf = w_full[W];
      end
      2'b01: begin
        w_res = w_diff;
        w_ovf = w_borrow;
      end
      2'b10: begin
        w_res = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
        w_ovf = w_full[W];
      end
      default: begin
        w_res = w_borrow ? {W{1'b0}} : w_diff;
        w_ovf = w_borrow;
      end
    endcase
  end

  assign valid     = r_vld[STAGES-1];
  assign y         = r_y[STAGES-1];
  assign ovf       = r_ovf[STAGES-1];
  assign w_advance = !valid || out_ready;
  assign in_ready  = w_advance && !flush;
  assign w_accept  = start && in_ready;

  // The whole chain moves as one unit, so a stall freezes every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_y   <= '0;
      r_ovf <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (w_advance) begin
      r_vld[0] <= w_accept;
      r_y[0]   <= w_res;
      r_ovf[0] <= w_ovf;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_y[s]   <= r_y[s-1];
        r_ovf[s] <= r_ovf[s-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int s = 0; s < STAGES; s++) begin
      inflight = inflight + CW'(r_vld[s]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_addsub_unit
// Brief   : Randomised bench for pipe_addsub_unit (W=20, STAGES=3 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_addsub_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [19:0] a;
  logic [19:0] b;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  in_ready1;
  logic [19:0] y,         y1;
  logic        ovf,       ovf1;
  logic        valid,     valid1;
  logic [1:0]  inflight;
  logic [0:0]  inflight1;

  int total = 0;
  int bad   = 0;
  logic [20:0] q[$];

  pipe_addsub_unit #(.W(20), .STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .in_ready(in_ready), .flush(flush), .y(y), .ovf(ovf), .valid(valid),
    .out_ready(out_ready), .inflight(inflight)
  );

  pipe_addsub_unit #(.W(20), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .in_ready(in_ready1), .flush(flush), .y(y1), .ovf(ovf1), .valid(valid1),
    .out_ready(out_ready), .inflight(inflight1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, y} from plain unsigned integer arithmetic
  function automatic logic [20:0] model(input logic [1:0] o, input logic [19:0] x, input logic [19:0] z);
    logic [31:0] m, s, r;
    logic        f;
    m = 32'd1 << 20;
    s = 32'(x) + 32'(z);
    case (o)
      2'd0:    begin f = (s >= m);         r = s % m; end
      2'd1:    begin f = (x < z);          r = (32'(x) + m - 32'(z)) % m; end
      2'd2:    begin f = (s >= m);         r = f ? m - 1 : s; end
      default: begin f = (x < z);          r = f ? 32'd0 : 32'(x) - 32'(z); end
    endcase
    return {f, r[19:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op = 2'd0; a = 20'd1; b = 20'd2;
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0 || y !== 20'd0 || inflight !== 2'd0 || valid1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: valid=%b y=%h inflight=%0d valid1=%b want 0/0/0/0", valid, y, inflight, valid1);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); start = 1'b1; a = 20'd10; b = 20'd20;
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    total++;
    if (inflight !== 2'd2) begin bad++; $display("FAIL reset_prefill: inflight got %0d want 2", inflight); end
    rst_n = 1'b0;
    #1;
    total++;
    if (inflight !== 2'd0 || valid !== 1'b0) begin
      bad++; $display("FAIL reset_async: inflight=%0d valid=%b want 0/0", inflight, valid);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_discard: valid got %b want 0 (cycle %0d)", valid, i); end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 20'd5; b = 20'd7; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        total++;
        if (valid1 !== 1'b1 || y1 !== 20'd12 || ovf1 !== 1'b0) begin
          bad++; $display("FAIL latency_s1: valid1=%b y1=%0d ovf1=%b want 1/12/0", valid1, y1, ovf1);
        end
      end
      total++;
      if (i < 3 && valid !== 1'b0) begin
        bad++; $display("FAIL latency_early: valid got %b want 0 after edge k+%0d", valid, i);
      end else if (i == 3 && (valid !== 1'b1 || y !== 20'd12 || ovf !== 1'b0)) begin
        bad++; $display("FAIL latency_s3: valid=%b y=%0d ovf=%b want 1/12/0", valid, y, ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [1:0]  ops [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [19:0] as  [4] = '{20'hFFFFF, 20'hFFFFF, 20'd3, 20'd3};
    logic [19:0] bs  [4] = '{20'd1, 20'd1, 20'd5, 20'd5};
    logic [19:0] ys  [4] = '{20'h00000, 20'hFFFFF, 20'hFFFFE, 20'h00000};
    int w;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      start = 1'b1; op = ops[m]; a = as[m]; b = bs[m];
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (valid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
      total++;
      if (valid !== 1'b1 || y !== ys[m] || ovf !== 1'b1) begin
        bad++; $display("FAIL mode_%0d: valid=%b y=%h ovf=%b want 1/%h/1", ops[m], valid, y, ovf, ys[m]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int sent = 0, got = 0;
    logic pv = 1'b0, po = 1'b1, acc, con, povf = 1'b0;
    logic [19:0] py = 20'd0;
    q.delete();
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 8);
      start = (sent < 6); op = 2'($urandom); a = 20'($urandom); b = 20'($urandom);
      #1;
      if (valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0 (c=%0d)", in_ready, c); end
      end
      if (c == 6) begin
        total++;
        if (inflight !== 2'd3) begin bad++; $display("FAIL bp_inflight: got %0d want 3", inflight); end
      end
      if (pv && !po) begin
        total++;
        if (valid !== 1'b1 || y !== py || ovf !== povf) begin
          bad++; $display("FAIL bp_hold: valid=%b y=%h ovf=%b want 1/%h/%b", valid, y, ovf, py, povf);
        end
      end
      con = valid && out_ready;
      acc = start && (!valid || out_ready);
      if (valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_spurious: y=%h want no output", y);
        end else if ({ovf, y} !== q[0]) begin
          bad++; $display("FAIL bp_data: got %h want %h", {ovf, y}, q[0]);
        end
      end
      if (con && q.size() != 0) begin void'(q.pop_front()); got++; end
      if (acc) begin q.push_back(model(op, a, b)); sent++; end
      pv = valid; po = out_ready; py = y; povf = ovf;
    end
    start = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 6 || sent != 6) begin bad++; $display("FAIL bp_count: got %0d sent %0d want 6/6", got, sent); end
  endtask

  task automatic test_flush();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 20'(i + 1); b = 20'd1;
    end
    @(negedge clk);
    total++;
    if (inflight !== 2'd3) begin bad++; $display("FAIL flush_prefill: inflight got %0d want 3", inflight); end
    flush = 1'b1; start = 1'b1; a = 20'd9; b = 20'd9;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    total++;
    if (valid !== 1'b0 || inflight !== 2'd0) begin
      bad++; $display("FAIL flush_clear: valid=%b inflight=%0d want 0/0", valid, inflight);
    end
    start = 1'b1; a = 20'd100; b = 20'd23; op = 2'd0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (valid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    total++;
    if (valid !== 1'b1 || y !== 20'd123 || ovf !== 1'b0) begin
      bad++; $display("FAIL flush_after: valid=%b y=%0d ovf=%b want 1/123/0", valid, y, ovf);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL flush_stale: valid got %b y=%0d want 0", valid, y); end
    end
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    logic pv = 1'b0, po = 1'b1, acc, con, povf = 1'b0;
    logic [19:0] py = 20'd0;
    q.delete();
    flush = 1'b0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      start = (sent < 1000) && ($urandom_range(0, 1) == 1);
      op = 2'($urandom); a = 20'($urandom); b = 20'($urandom);
      out_ready = (sent >= 1000) || ($urandom_range(0, 1) == 1);
      #1;
      total++;
      if (in_ready !== (!valid || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, !valid || out_ready);
      end
      total++;
      if (int'(inflight) != q.size()) begin
        bad++; $display("FAIL rnd_inflight: got %0d want %0d", inflight, q.size());
      end
      if (pv && !po) begin
        total++;
        if (valid !== 1'b1 || y !== py || ovf !== povf) begin
          bad++; $display("FAIL rnd_hold: valid=%b y=%h ovf=%b want 1/%h/%b", valid, y, ovf, py, povf);
        end
      end
      con = valid && out_ready;
      acc = start && (!valid || out_ready);
      if (valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious: y=%h want no output", y);
        end else if ({ovf, y} !== q[0]) begin
          bad++; $display("FAIL rnd_data: got %h want %h (result %0d)", {ovf, y}, q[0], got);
        end
      end
      if (con && q.size() != 0) begin void'(q.pop_front()); got++; end
      if (acc) begin q.push_back(model(op, a, b)); sent++; end
      pv = valid; po = out_ready; py = y; povf = ovf;
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 1000 || cyc >= 20000) begin
      bad++; $display("FAIL rnd_count: got %0d results in %0d cycles want 1000", got, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_pressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
